prod_accum: RTL and testbench

- Downstream consumer of the 8-bit signed 4x4 product stage.
- Accepts a stream of two's-complement products over a valid/ready handshake and sign-extends each to ACC_W bits.
- Sums LEN consecutive products into one block result and presents it on a valid/ready output port with backpressure.
- Feeds the dot-product/result-capture logic of the lab datapath.

---
 rtl/prod_accum_if.sv | 28 ++
 rtl/prod_accum.sv | 175 +++++++++++++++++
 tb/tb_prod_accum.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prod_accum_if.sv
// prod_accum_if - product-stream input, block-result output and flush control
// for the prod_accum block sum stage.
//   master : upstream/consumer side (drives product stream, flush, out_ready)
//   slave  : prod_accum itself
interface prod_accum_if #(
   parameter int ACC_W = 12,
   parameter int CNT_W = 2
);
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       product;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_out;
   logic             ovf;
   logic [CNT_W-1:0] cnt;

   modport master (
      output clr, in_valid, product, out_ready,
      input  in_ready, out_valid, acc_out, ovf, cnt
   );

   modport slave (
      input  clr, in_valid, product, out_ready,
      output in_ready, out_valid, acc_out, ovf, cnt
   );
endinterface

// File: rtl/prod_accum.sv
// prod_accum - sums LEN consecutive signed 8-bit products into one ACC_W-bit
// block result, presented on a valid/ready port with backpressure.
//
// Build option:
//   PROD_ACCUM_SAT_EN  defined   -> saturating accumulation with a per-block
//                                   sticky overflow flag reported on ovf.
//                      undefined -> two's-complement wrap, ovf tied low.
//
// Two states: ACCUM (taking products) and HOLD (result pending). Leaving HOLD
// costs one bubble cycle because in_ready is derived from the registered state.
module prod_accum #(
   parameter int ACC_W = 12,
   parameter int LEN   = 4,
   parameter int CNT_W = 2
) (
   input  logic         clk,
   input  logic         rst,
   prod_accum_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t           state_r;
   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] acc_out_r;
   logic [CNT_W-1:0] cnt_r;
   logic             out_valid_r;

   logic [ACC_W-1:0] ext_s;
   logic [ACC_W-1:0] sum_s;
   logic             in_hs_s;
   logic             out_hs_s;
   logic             last_s;

   // Sign-extend a product to the accumulator width.
   function automatic logic [ACC_W-1:0] sext(input logic [7:0] p);
      return {{(ACC_W-8){p[7]}}, p};
   endfunction

`ifdef PROD_ACCUM_SAT_EN
   logic sum_ovf_s;
   logic ovf_r;
   logic sticky_r;

   // Signed overflow: operands agree in sign and the raw sum disagrees.
   function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                    input logic [ACC_W-1:0] b);
      logic [ACC_W-1:0] s;
      s = a + b;
      return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
   endfunction

   // Add with clamp to the most positive/negative value on overflow.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
      logic [ACC_W-1:0] s;
      s = a + b;
      if (add_ovf(a, b)) begin
         if (a[ACC_W-1]) begin
            s = {1'b1, {(ACC_W-1){1'b0}}};
         end else begin
            s = {1'b0, {(ACC_W-1){1'b1}}};
         end
      end else begin
         s = a + b;
      end
      return s;
   endfunction
`endif

   // Handshake qualification and next running sum.
   always_comb begin
      ext_s    = sext(bus.product);
      in_hs_s  = (state_r == ST_ACCUM) && bus.in_valid;
      out_hs_s = out_valid_r && bus.out_ready;
      last_s   = (cnt_r == CNT_W'(LEN-1));
`ifdef PROD_ACCUM_SAT_EN
      sum_s     = sat_add(acc_r, ext_s);
      sum_ovf_s = add_ovf(acc_r, ext_s);
`else
      sum_s     = acc_r + ext_s;
`endif
   end

   // Block FSM: accumulate LEN products, then hold the result until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_ACCUM;
         acc_r       <= {ACC_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         acc_out_r   <= {ACC_W{1'b0}};
         out_valid_r <= 1'b0;
      end else if (bus.clr) begin
         // Flush drops the partial block and any pending result; acc_out
         // keeps its last value so a late reader sees a stable bus.
         state_r     <= ST_ACCUM;
         acc_r       <= {ACC_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_ACCUM: begin
               if (in_hs_s) begin
                  if (last_s) begin
                     acc_out_r   <= sum_s;
                     acc_r       <= {ACC_W{1'b0}};
                     cnt_r       <= {CNT_W{1'b0}};
                     out_valid_r <= 1'b1;
                     state_r     <= ST_HOLD;
                  end else begin
                     acc_r <= sum_s;
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end else begin
                  acc_r <= acc_r;
               end
            end
            ST_HOLD: begin
               if (out_hs_s) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ST_ACCUM;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_ACCUM;
               acc_r       <= {ACC_W{1'b0}};
               cnt_r       <= {CNT_W{1'b0}};
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef PROD_ACCUM_SAT_EN
   // Per-block sticky overflow; copied to ovf alongside the block result.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r    <= 1'b0;
         sticky_r <= 1'b0;
      end else if (bus.clr) begin
         sticky_r <= 1'b0;
         if (state_r == ST_HOLD) begin
            ovf_r <= 1'b0;
         end else begin
            ovf_r <= ovf_r;
         end
      end else if (in_hs_s) begin
         if (last_s) begin
            ovf_r    <= sticky_r | sum_ovf_s;
            sticky_r <= 1'b0;
         end else begin
            sticky_r <= sticky_r | sum_ovf_s;
         end
      end else begin
         sticky_r <= sticky_r;
      end
   end

   assign bus.ovf = ovf_r;
`else
   assign bus.ovf = 1'b0;
`endif

   // in_ready follows the registered state, masked while reset is applied.
   assign bus.in_ready  = (state_r == ST_ACCUM) && !rst;
   assign bus.out_valid = out_valid_r;
   assign bus.acc_out   = acc_out_r;
   assign bus.cnt       = cnt_r;

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum - self-checking bench for prod_accum.
// Main instance uses ACC_W=12; a second ACC_W=9 instance covers overflow.
// Expected values come from a block-level model: a buffer of accepted
// products summed with integer arithmetic when LEN of them have arrived.
module tb_prod_accum;
   localparam int LEN = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prod_accum_if #(.ACC_W(12), .CNT_W(2)) b12 ();
   prod_accum_if #(.ACC_W(9),  .CNT_W(2)) b9 ();

   prod_accum #(.ACC_W(12), .LEN(LEN), .CNT_W(2)) u_dut (
      .clk(clk), .rst(rst), .bus(b12.slave));
   prod_accum #(.ACC_W(9), .LEN(LEN), .CNT_W(2)) u_dut9 (
      .clk(clk), .rst(rst), .bus(b9.slave));

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state for the 12-bit instance
   int m_buf[4];
   int m_n    = 0;
   bit m_pend = 1'b0;
   int m_res  = 0;
   bit m_ovf  = 1'b0;

   // Sum of one block at width w; wraps, or clamps per step with SAT.
   function automatic int block_sum(input int vals[4], input int w, output bit o);
      int acc;
      int hi;
      int lo;
      acc = 0;
      hi  = (1 << (w-1)) - 1;
      lo  = -(1 << (w-1));
      o   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         acc = acc + vals[i];
`ifdef PROD_ACCUM_SAT_EN
         if (acc > hi) begin acc = hi; o = 1'b1; end
         else if (acc < lo) begin acc = lo; o = 1'b1; end
`endif
      end
      return acc & ((1 << w) - 1);
   endfunction

   task automatic model_step(input logic r, input logic c, input logic v,
                             input logic [7:0] p, input logic ordy);
      bit o;
      if (r) begin
         m_n = 0; m_pend = 1'b0; m_res = 0; m_ovf = 1'b0;
      end else if (c) begin
         m_n = 0;
         if (m_pend) begin m_pend = 1'b0; m_ovf = 1'b0; end
      end else if (m_pend) begin
         if (ordy) m_pend = 1'b0;
      end else if (v) begin
         m_buf[m_n] = int'($signed(p));
         m_n = m_n + 1;
         if (m_n == LEN) begin
            m_res  = block_sum(m_buf, 12, o);
            m_ovf  = o;
            m_n    = 0;
            m_pend = 1'b1;
         end
      end
   endtask

   // Advance the model with current inputs, then one clock; sample at +1.
   task automatic tick();
      model_step(rst, b12.clr, b12.in_valid, b12.product, b12.out_ready);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; b12.clr = 1'b0; b12.in_valid = 1'b1; b12.product = 8'h55;
      b12.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_chk++;
         if (b12.out_valid !== 1'b0 || b12.acc_out !== 12'h000 || b12.cnt !== 2'd0 ||
             b12.in_ready !== 1'b0 || b12.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state[%0d]: out_valid=%b acc_out=%h cnt=%0d in_ready=%b ovf=%b, want 0 000 0 0 0",
                     i, b12.out_valid, b12.acc_out, b12.cnt, b12.in_ready, b12.ovf);
         end
      end
      rst = 1'b0; b12.in_valid = 1'b0;
      #1;
      n_chk++;
      if (b12.in_ready !== 1'b1 || b9.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: in_ready=%b/%b, want 1/1", b12.in_ready, b9.in_ready);
      end
   endtask

   task automatic test_mixed_sign();
      int prods[4] = '{6, -8, 64, -56};
      b12.out_ready = 1'b1; b12.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b12.product = 8'(prods[i]);
         tick();
      end
      n_chk++;
      if (b12.out_valid !== 1'b1 || b12.acc_out !== 12'(m_res) || b12.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mixed_result: out_valid=%b acc_out=%h in_ready=%b, want 1 %h 0",
                  b12.out_valid, b12.acc_out, b12.in_ready, 12'(m_res));
      end
      tick();
      n_chk++;
      if (b12.out_valid !== 1'b0 || b12.in_ready !== 1'b1 || b12.cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL mixed_bubble: out_valid=%b in_ready=%b cnt=%0d, want 0 1 0",
                  b12.out_valid, b12.in_ready, b12.cnt);
      end
      b12.in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      b12.out_ready = 1'b0; b12.in_valid = 1'b1; b12.product = 8'd10;
      repeat (4) tick();
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (b12.out_valid !== 1'b1 || b12.acc_out !== 12'd40 || b12.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: out_valid=%b acc_out=%0d in_ready=%b, want 1 40 0",
                     i, b12.out_valid, b12.acc_out, b12.in_ready);
         end
         tick();
      end
      b12.out_ready = 1'b1;
      tick();
      n_chk++;
      if (b12.out_valid !== 1'b0 || b12.in_ready !== 1'b1 || b12.cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b cnt=%0d, want 0 1 0",
                  b12.out_valid, b12.in_ready, b12.cnt);
      end
      tick();
      n_chk++;
      if (b12.cnt !== 2'd1 || b12.cnt !== 2'(m_n)) begin
         n_fail++;
         $display("FAIL bp_first_after: cnt=%0d, want 1", b12.cnt);
      end
      b12.in_valid = 1'b0; b12.out_ready = 1'b0;
   endtask

   task automatic test_flush();
      b12.clr = 1'b1; tick(); b12.clr = 1'b0;
      b12.in_valid = 1'b1;
      b12.product = 8'd5; tick();
      b12.product = 8'd7; tick();
      n_chk++;
      if (b12.cnt !== 2'd2) begin
         n_fail++; $display("FAIL flush_pre: cnt=%0d, want 2", b12.cnt);
      end
      b12.clr = 1'b1; b12.product = 8'd9; tick(); b12.clr = 1'b0;
      n_chk++;
      if (b12.cnt !== 2'd0 || b12.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_clr: cnt=%0d out_valid=%b, want 0 0", b12.cnt, b12.out_valid);
      end
      b12.product = 8'd1; b12.out_ready = 1'b1;
      repeat (4) tick();
      b12.in_valid = 1'b0;
      n_chk++;
      if (b12.out_valid !== 1'b1 || b12.acc_out !== 12'd4 || b12.acc_out !== 12'(m_res)) begin
         n_fail++; $display("FAIL flush_result: out_valid=%b acc_out=%0d, want 1 4", b12.out_valid, b12.acc_out);
      end
      tick();
      // flush while a result is pending
      b12.in_valid = 1'b1; b12.product = 8'd20; b12.out_ready = 1'b0;
      repeat (4) tick();
      b12.in_valid = 1'b0;
      n_chk++;
      if (b12.out_valid !== 1'b1 || b12.acc_out !== 12'd80) begin
         n_fail++; $display("FAIL hold_pre: out_valid=%b acc_out=%0d, want 1 80", b12.out_valid, b12.acc_out);
      end
      b12.clr = 1'b1; tick(); b12.clr = 1'b0;
      n_chk++;
      if (b12.out_valid !== 1'b0 || b12.acc_out !== 12'd80 || b12.in_ready !== 1'b1 || b12.ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_clr: out_valid=%b acc_out=%0d in_ready=%b ovf=%b, want 0 80 1 0",
                  b12.out_valid, b12.acc_out, b12.in_ready, b12.ovf);
      end
   endtask

   task automatic test_stall_gaps();
      bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      int exp_cnt = 0;
      b12.out_ready = 1'b0; b12.product = 8'd3;
      for (int i = 0; i < 7; i++) begin
         b12.in_valid = pat[i];
         tick();
         if (pat[i]) exp_cnt++;
         if (i < 6) begin
            n_chk++;
            if (b12.cnt !== 2'(exp_cnt)) begin
               n_fail++; $display("FAIL stall_cnt[%0d]: cnt=%0d, want %0d", i, b12.cnt, exp_cnt);
            end
         end
      end
      b12.in_valid = 1'b0;
      n_chk++;
      if (b12.out_valid !== 1'b1 || b12.acc_out !== 12'd12 || b12.cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL stall_result: out_valid=%b acc_out=%0d cnt=%0d, want 1 12 0",
                  b12.out_valid, b12.acc_out, b12.cnt);
      end
      b12.out_ready = 1'b1; tick(); b12.out_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst           = ($urandom_range(0, 59) == 0);
         b12.clr       = ($urandom_range(0, 24) == 0);
         b12.in_valid  = 1'($urandom_range(0, 1));
         b12.out_ready = ($urandom_range(0, 2) != 0);
         b12.product   = 8'($urandom);
         #1;
         n_chk++;
         if (b12.in_ready !== (!m_pend && !rst)) begin
            n_fail++; $display("FAIL rand_ready[%0d]: in_ready=%b, want %b", i, b12.in_ready, !m_pend && !rst);
         end
         tick();
         n_chk++;
         if (b12.out_valid !== m_pend || b12.cnt !== 2'(m_n) || b12.acc_out !== 12'(m_res) ||
             b12.ovf !== m_ovf) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: out_valid=%b cnt=%0d acc_out=%h ovf=%b, want %b %0d %h %b",
                     i, b12.out_valid, b12.cnt, b12.acc_out, b12.ovf, m_pend, m_n, 12'(m_res), m_ovf);
         end
      end
      rst = 1'b0; b12.clr = 1'b0; b12.in_valid = 1'b0; b12.out_ready = 1'b1;
      tick();
   endtask

   task automatic test_overflow();
      int vals[4];
      int exp;
      bit o;
      for (int blk = 0; blk < 5; blk++) begin
         b9.out_ready = 1'b0; b9.in_valid = 1'b1;
         for (int j = 0; j < 4; j++) begin
            if (blk == 0)      vals[j] = 64;
            else if (blk == 1) vals[j] = -128;
            else               vals[j] = int'($urandom_range(0, 255)) - 128;
            b9.product = 8'(vals[j]);
            tick();
         end
         b9.in_valid = 1'b0;
         exp = block_sum(vals, 9, o);
         n_chk++;
         if (b9.out_valid !== 1'b1 || b9.acc_out !== 9'(exp) || b9.ovf !== o) begin
            n_fail++;
            $display("FAIL ovf_block[%0d]: out_valid=%b acc_out=%h ovf=%b, want 1 %h %b",
                     blk, b9.out_valid, b9.acc_out, b9.ovf, 9'(exp), o);
         end
         if (blk == 0) begin
            n_chk++;
`ifdef PROD_ACCUM_SAT_EN
            if (b9.acc_out !== 9'h0FF || b9.ovf !== 1'b1) begin
               n_fail++; $display("FAIL ovf_sat64: acc_out=%h ovf=%b, want 0ff 1", b9.acc_out, b9.ovf);
            end
`else
            if (b9.acc_out !== 9'h100 || b9.ovf !== 1'b0) begin
               n_fail++; $display("FAIL ovf_wrap64: acc_out=%h ovf=%b, want 100 0", b9.acc_out, b9.ovf);
            end
`endif
         end
         b9.out_ready = 1'b1; tick(); b9.out_ready = 1'b0;
         n_chk++;
         if (b9.out_valid !== 1'b0 || b9.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ovf_release[%0d]: out_valid=%b in_ready=%b, want 0 1",
                               blk, b9.out_valid, b9.in_ready);
         end
      end
   endtask

   initial begin
      b9.clr = 1'b0; b9.in_valid = 1'b0; b9.product = 8'h00; b9.out_ready = 1'b0;
      b12.clr = 1'b0; b12.in_valid = 1'b0; b12.product = 8'h00; b12.out_ready = 1'b0;
      test_reset();
      test_mixed_sign();
      test_backpressure();
      test_flush();
      test_stall_gaps();
      test_random();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
